in_buf: RTL and testbench
=========================

# in_buf

Input staging buffer for one row or column of the systolic array. It holds a FIFO of operand words and releases one word per read. Each word passes through a configurable chain of skew registers (PADDING) so that neighbouring lanes enter the array on the diagonal wavefront. Cycles with no read inject zero bubbles into the skew chain.

## Interface
- WIDTH, 8, data word width in bits.
- DEPTH, 8, FIFO entries; power of two, ≥2.
- PADDING, 0, number of extra skew register stages after the FIFO output register; any value 0..63 is legal.

- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset; asynchronous and active-high.
- read  in  1  pop request.
- write  in  1  push request.
- din  in  WIDTH  write data, sampled on the rising edge of clk when write=1.
- full  out  1  FIFO holds DEPTH entries.
- empty  out  1  FIFO holds 0 entries.
- dout  out  WIDTH  skewed output word.
- err  out  1  sticky error flag; present only with IN_BUF_ERR_FLAG_EN.

## Operation
- State consists of:
  - storage mem[DEPTH];
  - wptr and rptr, each log2(DEPTH) bits, wrapping modulo DEPTH;
  - count, log2(DEPTH)+1 bits;
  - output register s0;
  - skew registers s1..sPADDING.
- Push is accepted when write=1 and (!full, or a pop is accepted in the same cycle). mem[wptr]<=din and wptr increments.
- Pop is accepted when read=1 and !empty. s0<=mem[rptr] and rptr increments.
- When no pop is accepted, s0<=0 (zero bubble).
- Simultaneous write and read:
  - FIFO non-empty: both accepted, count unchanged.
  - FIFO empty: write accepted, read ignored. There is no bypass: s0<=0 and count becomes 1.
  - FIFO full: both accepted.
- Write while full with no accepted pop: ignored, no state change.
- Read while empty: ignored; s0<=0.
- Skew chain: s(k)<=s(k-1) every cycle for k=1..PADDING. dout=sPADDING, or dout=s0 when PADDING=0.
- full = (count==DEPTH); empty = (count==0). Both are decoded combinationally from registered count.

## Timing
- Reset, asynchronous and effective immediately on assertion:
  - all pointers, count and skew registers cleared;
  - empty=1, full=0, dout=0, err=0.
- Release of rst takes effect at the next clock edge; the first edge with rst=0 can accept a push.
- Push-to-empty-deassert: empty falls after the edge that accepts the push.
- Read latency: a word popped at edge N appears on dout after edge N+PADDING, i.e. 1+PADDING cycles after read is sampled.
- dout holds each word for exactly one cycle. Back-to-back pops give back-to-back words.
- full and empty update in the same cycle as count.
- Reset asserted mid-operation discards FIFO contents and in-flight skew data.

## Configuration
- IN_BUF_ERR_FLAG_EN defined:
  - adds output err;
  - err is set at any edge where a write is ignored due to full, or read=1 while empty;
  - err stays set until rst.
- IN_BUF_ERR_FLAG_EN undefined:
  - port err and its logic are absent;
  - overflow and underflow are silently ignored as described in Operation.

## Test plan
- Reset: assert rst mid-cycle with no clock edge → dout=0, empty=1, full=0 immediately.
- Write-only then mixed traffic (PADDING=0, DEPTH=8):
  - write din=1 for one cycle, then write+read for 5 cycles with din=2..6;
  - → dout=1,2,3,4,5 on consecutive cycles, each one cycle after its read;
  - count stays 1 and empty=0 throughout.
- Fill then drain:
  - continuing the previous scenario, write-only din=7,8,9 for 3 cycles, then read-only for 6 cycles;
  - → dout=6,7,8,9,0,0;
  - empty rises after the 4th read;
  - err=1 after the 5th read when IN_BUF_ERR_FLAG_EN is set.
- Skew: repeat the mixed-traffic sequence with PADDING=3 and PADDING=7 → same dout sequence delayed by exactly 3 and 7 additional cycles; zeros in all gaps.
- Full boundary:
  - write 8 words (0x10..0x17) → full=1;
  - a 9th write of 0xFF is ignored;
  - write+read while full pops 0x10 and stores the new word;
  - draining yields 0x11..0x17 and then the new word, never 0xFF;
  - pointer wrap is verified.
- Simultaneous read+write on empty: din=0xAA → s0=0, count=1; the next read alone returns 0xAA after 1+PADDING cycles.

Source files
------------

// File: rtl/in_buf_if.sv
// Handshake/data bundle for in_buf; the err member exists only when
// IN_BUF_ERR_FLAG_EN is defined.
interface in_buf_if #(
  parameter int WIDTH = 8
) ();
  logic             read;
  logic             write;
  logic [WIDTH-1:0] din;
  logic             full;
  logic             empty;
  logic [WIDTH-1:0] dout;
`ifdef IN_BUF_ERR_FLAG_EN
  logic             err;
`endif

`ifdef IN_BUF_ERR_FLAG_EN
  modport master (output read, write, din, input full, empty, dout, err);
  modport slave  (input read, write, din, output full, empty, dout, err);
`else
  modport master (output read, write, din, input full, empty, dout);
  modport slave  (input read, write, din, output full, empty, dout);
`endif
endinterface

// File: rtl/in_buf.sv
// Systolic-array input staging buffer: FIFO followed by a PADDING-deep skew chain.
// Optional sticky overflow/underflow flag enabled by macro IN_BUF_ERR_FLAG_EN.
module in_buf #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 8,
  parameter int PADDING = 0
) (
  input  logic   clk,
  input  logic   rst,
  in_buf_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  // skew_q[0] is the FIFO output register s0; skew_q[PADDING] drives dout
  logic [WIDTH-1:0] skew_q [PADDING+1];
  logic [WIDTH-1:0] s0_d;
  logic             full_s, empty_s, push_s, pop_s;

  always_comb begin
    full_s  = (count_q == CW'(DEPTH));
    empty_s = (count_q == {CW{1'b0}});
    pop_s   = bus.read & ~empty_s;
    // a full FIFO still takes a write when the same edge frees a slot
    push_s  = bus.write & (~full_s | pop_s);

    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    s0_d    = {WIDTH{1'b0}};

    if (push_s) begin
      wptr_d = wptr_q + 1'b1;
    end else begin
      wptr_d = wptr_q;
    end

    if (pop_s) begin
      rptr_d = rptr_q + 1'b1;
      s0_d   = mem_q[rptr_q];
    end else begin
      rptr_d = rptr_q;
      s0_d   = {WIDTH{1'b0}};
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= {AW{1'b0}};
      rptr_q  <= {AW{1'b0}};
      count_q <= {CW{1'b0}};
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k <= PADDING; k++) begin
        skew_q[k] <= {WIDTH{1'b0}};
      end
    end else begin
      skew_q[0] <= s0_d;
      for (int k = 1; k <= PADDING; k++) begin
        skew_q[k] <= skew_q[k-1];
      end
    end
  end

  // storage array carries no reset; only words below count are ever read
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wptr_q] <= bus.din;
    end
  end

  assign bus.full  = full_s;
  assign bus.empty = empty_s;
  assign bus.dout  = skew_q[PADDING];

`ifdef IN_BUF_ERR_FLAG_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q | (bus.write & full_s & ~pop_s) | (bus.read & empty_s);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.err = err_q;
`endif
endmodule

// File: tb/tb_in_buf.sv
// Self-checking bench for in_buf: three instances (PADDING 0, 3, 7) share one
// stimulus stream and are compared against a queue-based reference model.
module tb_in_buf;
  localparam int W = 8;
  localparam int D = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  in_buf_if #(.WIDTH(W)) bus0 ();
  in_buf_if #(.WIDTH(W)) bus3 ();
  in_buf_if #(.WIDTH(W)) bus7 ();

  in_buf #(.WIDTH(W), .DEPTH(D), .PADDING(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  in_buf #(.WIDTH(W), .DEPTH(D), .PADDING(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));
  in_buf #(.WIDTH(W), .DEPTH(D), .PADDING(7)) dut7 (.clk(clk), .rst(rst), .bus(bus7));

  int n_checks = 0;
  int n_errors = 0;

  // reference model: FIFO contents, per-cycle s0 history, sticky error
  logic [W-1:0] mq[$];
  logic [W-1:0] hist[$];
  logic         m_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // word popped P edges ago emerges on a PADDING=P lane; zeros before history
  function automatic logic [W-1:0] exp_dout(input int p);
    if (hist.size() > p) return hist[hist.size() - 1 - p];
    return '0;
  endfunction

  task automatic drive(input logic r, input logic w, input logic [W-1:0] d);
    bus0.read = r; bus0.write = w; bus0.din = d;
    bus3.read = r; bus3.write = w; bus3.din = d;
    bus7.read = r; bus7.write = w; bus7.din = d;
  endtask

  task automatic check_all();
    check("dout_p0", {24'd0, bus0.dout}, {24'd0, exp_dout(0)});
    check("dout_p3", {24'd0, bus3.dout}, {24'd0, exp_dout(3)});
    check("dout_p7", {24'd0, bus7.dout}, {24'd0, exp_dout(7)});
    check("full",    {31'd0, bus0.full},  {31'd0, (mq.size() == D)});
    check("empty",   {31'd0, bus0.empty}, {31'd0, (mq.size() == 0)});
    check("full_p7", {31'd0, bus7.full},  {31'd0, (mq.size() == D)});
    check("empty_p7",{31'd0, bus7.empty}, {31'd0, (mq.size() == 0)});
`ifdef IN_BUF_ERR_FLAG_EN
    check("err_p0",  {31'd0, bus0.err}, {31'd0, m_err});
    check("err_p7",  {31'd0, bus7.err}, {31'd0, m_err});
`endif
  endtask

  // one clock of traffic: update model from pre-edge state, then check after edge
  task automatic step(input logic r, input logic w, input logic [W-1:0] d);
    logic         full_m, empty_m, pop, push;
    logic [W-1:0] s0;
    drive(r, w, d);
    full_m  = (mq.size() == D);
    empty_m = (mq.size() == 0);
    pop     = r && !empty_m;
    push    = w && (!full_m || pop);
    s0      = '0;
    if (pop) s0 = mq.pop_front();
    if (push) mq.push_back(d);
    hist.push_back(s0);
    if ((w && full_m && !pop) || (r && empty_m)) m_err = 1'b1;
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_dout0"}, {24'd0, bus0.dout}, 32'd0);
    check({tag, "_dout3"}, {24'd0, bus3.dout}, 32'd0);
    check({tag, "_dout7"}, {24'd0, bus7.dout}, 32'd0);
    check({tag, "_empty"}, {31'd0, bus0.empty}, 32'd1);
    check({tag, "_full"},  {31'd0, bus0.full},  32'd0);
`ifdef IN_BUF_ERR_FLAG_EN
    check({tag, "_err"},   {31'd0, bus0.err},   32'd0);
`endif
  endtask

  // assert reset between edges and check its effect before any clock edge
  task automatic mid_cycle_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    check_reset_state(tag);
    mq.delete();
    hist.delete();
    m_err = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b0, 1'b0, '0);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, '0);
    #3;
    check_reset_state("por");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // write-only, then mixed traffic, then fill and drain
    step(1'b0, 1'b1, 8'd1);
    for (int i = 2; i <= 6; i++) step(1'b1, 1'b1, W'(i));
    for (int i = 7; i <= 9; i++) step(1'b0, 1'b1, W'(i));
    repeat (6) step(1'b1, 1'b0, 8'd0);
    repeat (8) step(1'b0, 1'b0, 8'd0);

    // full boundary, ignored overflow, write+read while full, drain with wrap
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, W'(8'h10 + i));
    check("full_after_8", {31'd0, bus0.full}, 32'd1);
    step(1'b0, 1'b1, 8'hFF);
    step(1'b1, 1'b1, 8'h20);
    check("pop_while_full", {24'd0, bus0.dout}, 32'h10);
    repeat (8) step(1'b1, 1'b0, 8'd0);
    repeat (8) step(1'b0, 1'b0, 8'd0);

    // reset with FIFO contents and skew data in flight
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, W'(8'h30 + i));
    step(1'b1, 1'b1, 8'h33);
    step(1'b1, 1'b1, 8'h34);
    mid_cycle_reset("mid");
    step(1'b0, 1'b0, 8'd0);

    // simultaneous read+write on empty: no bypass
    step(1'b1, 1'b1, 8'hAA);
    check("rw_empty_s0", {24'd0, bus0.dout}, 32'd0);
    check("rw_empty_cnt", {31'd0, bus0.empty}, 32'd0);
    step(1'b1, 1'b0, 8'd0);
    check("rw_empty_pop", {24'd0, bus0.dout}, 32'hAA);
    repeat (8) step(1'b0, 1'b0, 8'd0);

    // randomized phases alternating fill-biased and drain-biased traffic
    for (int ph = 0; ph < 12; ph++) begin
      int wp, rp;
      wp = (ph % 2 == 0) ? 80 : 30;
      rp = (ph % 2 == 0) ? 30 : 80;
      for (int c = 0; c < 200; c++) begin
        step($urandom_range(99) < rp, $urandom_range(99) < wp, W'($urandom));
      end
      if (ph == 5) mid_cycle_reset("rnd");
    end
    repeat (8) step(1'b0, 1'b0, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
